// File: rtl/jesd204b_phy_pkg.sv
// Shared state encodings, reset/ready output levels and counter sizing
// for the JESD204B PHY reset sequencer.
package jesd204b_phy_pkg;

  typedef enum logic [1:0] {T_ANA = 2'd0, T_LOCK = 2'd1, T_RDY = 2'd2} tx_state_e;
  typedef enum logic [1:0] {R_ANA = 2'd0, R_LTD = 2'd1, R_RDY = 2'd2} rx_state_e;
  typedef enum logic       {PLL_PD = 1'b0, PLL_RUN = 1'b1} pll_state_e;

  localparam logic RST_ON  = 1'b1;
  localparam logic RST_OFF = 1'b0;
  localparam logic RDY_ON  = 1'b1;
  localparam logic RDY_OFF = 1'b0;

  // One width fits every cycle counter, so each can hold its largest target.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/jesd204b_stable_filter.sv
// Debounce: q rises the cycle after N_CYC consecutive high samples of din
// and drops the cycle after any low sample or while clr is asserted.
module jesd204b_stable_filter
  import jesd204b_phy_pkg::*;
#(
  parameter int N_CYC = 64,
  parameter int CW    = $clog2(N_CYC + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic din,
  output logic q
);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // updates from pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset || clr || !din) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (cnt < CW'(N_CYC)) begin
      cnt <= cnt + CW'(1);
      q   <= (cnt == CW'(N_CYC - 1));
    end
  end

endmodule

// File: rtl/jesd204b_phy_reset_seq.sv
// Reset sequencer for JESD204B transceiver PLLs and lanes: PLL powerdown
// timing, per-lane analog/digital reset FSMs, soft reset and lock-loss recovery.
module jesd204b_phy_reset_seq
  import jesd204b_phy_pkg::*;
#(
  parameter int               N_TX          = 4,
  parameter int               N_RX          = 9,
  parameter int               N_PLL         = 3,
  parameter logic [2*N_TX-1:0] TX_PLL_MAP   = {2'd2, 2'd1, 2'd0, 2'd0},
  parameter int               PLL_PD_CYC    = 100,
  parameter int               ANA_CYC       = 50,
  parameter int               LOCK_FILT_CYC = 64,
  parameter int               LTD_CYC       = 400
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_TX-1:0]  tx_chan_reset,
  input  logic [N_RX-1:0]  rx_chan_reset,
  input  logic [N_PLL-1:0] pll_locked,
  input  logic [N_TX-1:0]  tx_cal_busy,
  input  logic [N_RX-1:0]  rx_cal_busy,
  input  logic [N_RX-1:0]  rx_is_lockedtodata,
  output logic [N_PLL-1:0] pll_powerdown,
  output logic [N_TX-1:0]  tx_analogreset,
  output logic [N_TX-1:0]  tx_digitalreset,
  output logic [N_RX-1:0]  rx_analogreset,
  output logic [N_RX-1:0]  rx_digitalreset,
  output logic [N_TX-1:0]  tx_ready,
  output logic [N_RX-1:0]  rx_ready,
  output logic [N_PLL-1:0] pll_locked_filt
);

  localparam int CW = cnt_width(PLL_PD_CYC, ANA_CYC, LOCK_FILT_CYC, LTD_CYC);

  logic [N_PLL-1:0] pll_run;

  for (genvar p = 0; p < N_PLL; p++) begin : g_pll
    pll_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pd_q;

    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == PLL_PD) begin
        if (cnt_q >= CW'(PLL_PD_CYC)) state_d = PLL_RUN;
        else                          cnt_d   = cnt_q + CW'(1);
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        state_q <= PLL_PD;
        cnt_q   <= '0;
        pd_q    <= RST_ON;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pd_q    <= (state_d == PLL_PD) ? RST_ON : RST_OFF;
      end
    end

    assign pll_run[p]       = (state_q == PLL_RUN);
    assign pll_powerdown[p] = pd_q;

    jesd204b_stable_filter #(.N_CYC(LOCK_FILT_CYC), .CW(CW)) u_lock_filt (
      .clock (clock),
      .reset (reset),
      .clr   (!pll_run[p]),
      .din   (pll_locked[p]),
      .q     (pll_locked_filt[p])
    );
  end

  for (genvar k = 0; k < N_TX; k++) begin : g_tx
    localparam int P = int'(TX_PLL_MAP[2*k +: 2]);
    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ana_q, dig_q, rdy_q;

    always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
        T_ANA: begin
          cnt_d = (cnt_q >= CW'(ANA_CYC)) ? cnt_q : cnt_q + CW'(1);
          if (pll_run[P] && !tx_cal_busy[k] && cnt_q >= CW'(ANA_CYC)) state_d = T_LOCK;
        end
        T_LOCK:  if (pll_locked_filt[P])  state_d = T_RDY;
        T_RDY:   if (!pll_locked_filt[P]) state_d = T_LOCK;
        default: state_d = T_ANA;
      endcase
      // Soft reset has priority over any lock-driven transition.
      if (tx_chan_reset[k]) begin
        state_d = T_ANA;
        cnt_d   = '0;
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        state_q <= T_ANA;
        cnt_q   <= '0;
        ana_q   <= RST_ON;
        dig_q   <= RST_ON;
        rdy_q   <= RDY_OFF;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        ana_q   <= (state_d == T_ANA) ? RST_ON : RST_OFF;
        dig_q   <= (state_d == T_RDY) ? RST_OFF : RST_ON;
        rdy_q   <= (state_d == T_RDY) ? RDY_ON : RDY_OFF;
      end
    end

    assign tx_analogreset[k]  = ana_q;
    assign tx_digitalreset[k] = dig_q;
    assign tx_ready[k]        = rdy_q;
  end

  for (genvar j = 0; j < N_RX; j++) begin : g_rx
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ana_q, dig_q, rdy_q, ltd_filt;

    jesd204b_stable_filter #(.N_CYC(LTD_CYC), .CW(CW)) u_ltd_filt (
      .clock (clock),
      .reset (reset),
      .clr   (state_q == R_ANA),
      .din   (rx_is_lockedtodata[j]),
      .q     (ltd_filt)
    );

    always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
        R_ANA: begin
          cnt_d = (cnt_q >= CW'(ANA_CYC)) ? cnt_q : cnt_q + CW'(1);
          if (!rx_cal_busy[j] && cnt_q >= CW'(ANA_CYC)) state_d = R_LTD;
        end
        R_LTD:   if (ltd_filt)               state_d = R_RDY;
        R_RDY:   if (!rx_is_lockedtodata[j]) state_d = R_LTD;
        default: state_d = R_ANA;
      endcase
      if (rx_chan_reset[j]) begin
        state_d = R_ANA;
        cnt_d   = '0;
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        state_q <= R_ANA;
        cnt_q   <= '0;
        ana_q   <= RST_ON;
        dig_q   <= RST_ON;
        rdy_q   <= RDY_OFF;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        ana_q   <= (state_d == R_ANA) ? RST_ON : RST_OFF;
        dig_q   <= (state_d == R_RDY) ? RST_OFF : RST_ON;
        rdy_q   <= (state_d == R_RDY) ? RDY_ON : RDY_OFF;
      end
    end

    assign rx_analogreset[j]  = ana_q;
    assign rx_digitalreset[j] = dig_q;
    assign rx_ready[j]        = rdy_q;
  end

endmodule
